// File: rtl/ps2_event_queue_pkg.sv
// Shared constants and watchdog state encoding for the PS/2 event queue.
package ps2_event_queue_pkg;

    localparam int EVT_W       = 10;
    localparam int DEPTH_DEF   = 8;
    localparam int TIMEOUT_DEF = 25000;

    localparam logic [3:0] BIT_CNT_MAX = 4'd10;

    typedef enum logic [1:0] {
        WD_IDLE    = 2'd0,
        WD_FRAME   = 2'd1,
        WD_RECOVER = 2'd2
    } wd_state_e;

    // An 11-bit PS/2 frame is counted 0..10, then wraps.
    function automatic logic [3:0] bit_cnt_inc(input logic [3:0] cnt);
        return (cnt == BIT_CNT_MAX) ? 4'd0 : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO with sticky overflow and synchronous flush.
module ps2_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int EVT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [EVT_W-1:0] push_data,
    input  logic             ack,
    input  logic             flush,
    output logic [EVT_W-1:0] data,
    output logic             valid,
    output logic [4:0]       count,
    output logic             overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [EVT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             pop;
    logic             do_push;

    assign valid   = (count != 5'd0);
    assign full    = (count == 5'(DEPTH));
    assign pop     = valid && ack;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || pop);
    assign data    = valid ? mem[rd_ptr] : '0;

    // NOTE: the storage array has no reset; ev_data is masked to zero while empty instead.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push && !do_push) overflow <= 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_event_queue.sv
// PS/2 event queue: decoder-event FIFO plus a frame watchdog that resets a stalled decoder.
module ps2_event_queue
    import ps2_event_queue_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ps2_clk,
    input  logic [EVT_W-1:0] rx_data,
    input  logic             rx_ready,
    output logic             rx_rst,
    output logic [EVT_W-1:0] ev_data,
    output logic             ev_valid,
    input  logic             ev_ack,
    input  logic             flush,
    output logic [4:0]       fifo_count,
    output logic             overflow,
    output logic [7:0]       timeout_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]    sync;
    logic          fall;
    logic          rx_ready_q;
    logic          push;
    wd_state_e     state, state_next;
    logic [3:0]    bit_cnt, bit_cnt_next;
    logic [TW-1:0] timer, timer_next;
    logic          rec_cnt, rec_next;
    logic          tcnt_inc;

    assign fall   = sync[2] && !sync[1];
    assign rx_rst = (state != WD_RECOVER);
    assign push   = rx_ready && !rx_ready_q && rx_rst && !flush;

    // NOTE: registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync        <= '0;
            rx_ready_q  <= 1'b0;
            state       <= WD_IDLE;
            bit_cnt     <= '0;
            timer       <= '0;
            rec_cnt     <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            sync        <= {sync[1:0], ps2_clk};
            rx_ready_q  <= rx_ready;
            state       <= state_next;
            bit_cnt     <= bit_cnt_next;
            timer       <= timer_next;
            rec_cnt     <= rec_next;
            if (tcnt_inc && timeout_cnt != 8'hFF) begin
                timeout_cnt <= timeout_cnt + 8'd1;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        timer_next   = timer;
        rec_next     = 1'b0;
        tcnt_inc     = 1'b0;
        case (state)
            WD_IDLE: begin
                if (fall) begin
                    bit_cnt_next = bit_cnt_inc(bit_cnt);
                    timer_next   = '0;
                    if (bit_cnt_next != 4'd0) state_next = WD_FRAME;
                end
            end
            WD_FRAME: begin
                if (fall) begin
                    bit_cnt_next = bit_cnt_inc(bit_cnt);
                    timer_next   = '0;
                    if (bit_cnt_next == 4'd0) state_next = WD_IDLE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_next = WD_RECOVER;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            WD_RECOVER: begin
                // Edges are ignored here; the decoder is held in reset for two cycles.
                bit_cnt_next = '0;
                timer_next   = '0;
                rec_next     = !rec_cnt;
                if (rec_cnt) begin
                    state_next = WD_IDLE;
                    tcnt_inc   = 1'b1;
                end
            end
            default: state_next = WD_IDLE;
        endcase
    end

    ps2_evt_fifo #(
        .DEPTH (DEPTH),
        .EVT_W (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (rx_data),
        .ack       (ev_ack),
        .flush     (flush),
        .data      (ev_data),
        .valid     (ev_valid),
        .count     (fifo_count),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_ps2_event_queue.sv
// Scoreboard bench: stimulus feeds a queue model, a negedge monitor compares DUT output against it.
module tb_ps2_event_queue;

    localparam int DEPTH = 8;
    localparam int TO    = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic [9:0] rx_data;
    logic       rx_ready;
    logic       rx_rst;
    logic [9:0] ev_data;
    logic       ev_valid;
    logic       ev_ack;
    logic       flush;
    logic [4:0] fifo_count;
    logic       overflow;
    logic [7:0] timeout_cnt;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [9:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    logic       prev_rdy = 1'b0;
    logic       mon_en = 1'b0;
    logic       chk_rx_rst = 1'b0;
    logic [9:0] last_pop = '0;

    ps2_event_queue #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .rx_rst      (rx_rst),
        .ev_data     (ev_data),
        .ev_valid    (ev_valid),
        .ev_ack      (ev_ack),
        .flush       (flush),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .timeout_cnt (timeout_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the model is updated after the edge the inputs were applied to.
    task automatic step(input logic rdy, input logic [9:0] d, input logic ack, input logic fl);
        logic is_push;
        rx_ready = rdy;
        rx_data  = d;
        ev_ack   = ack;
        flush    = fl;
        is_push  = rdy && !prev_rdy && !fl;
        prev_rdy = rdy;
        @(posedge clk);
        #1;
        if (fl) begin
            exp_q.delete();
            exp_ovf = 1'b0;
        end else if (is_push) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else exp_ovf = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 10'h000, 1'b0, 1'b0);
    endtask

    task automatic push_ev(input logic [9:0] d);
        step(1'b1, d, 1'b0, 1'b0);
        step(1'b0, 10'h000, 1'b0, 1'b0);
    endtask

    task automatic ps2_fall();
        ps2_clk = 1'b0;
        idle(4);
        ps2_clk = 1'b1;
        idle(4);
    endtask

    // Monitor: compares occupancy/flags every cycle and pops the scoreboard on each accepted ack.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
                check("ev_valid", 32'(ev_valid), 32'(exp_q.size() != 0));
                check("overflow", 32'(overflow), 32'(exp_ovf));
                if (chk_rx_rst) check("rx_rst_idle", 32'(rx_rst), 32'd1);
                if (exp_q.size() != 0) check("ev_data_head", 32'(ev_data), 32'(exp_q[0]));
                else check("ev_data_empty", 32'(ev_data), 32'd0);
                if (ev_valid && ev_ack && !flush) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL pop_data: got 0x%0h, expected no event", ev_data);
                    end else begin
                        last_pop = ev_data;
                        check("pop_data", 32'(ev_data), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout: got no finish, expected finish before limit");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int lows, first_low, last_low;
        logic seen;

        rst = 1'b0; ps2_clk = 1'b1; rx_data = '0; rx_ready = 1'b0; ev_ack = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ev_valid", 32'(ev_valid), 32'd0);
        check("rst_ev_data", 32'(ev_data), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
        check("rst_rx_rst", 32'(rx_rst), 32'd1);
        rst = 1'b1;
        mon_en = 1'b1;
        chk_rx_rst = 1'b1;
        idle(3);

        // First event appears one cycle after the push cycle.
        step(1'b1, 10'h01C, 1'b0, 1'b0);
        check("first_ev_valid", 32'(ev_valid), 32'd1);
        check("first_ev_data", 32'(ev_data), 32'h01C);
        check("first_count", 32'(fifo_count), 32'd1);
        step(1'b0, 10'h000, 1'b0, 1'b1);

        // Nine pushes into an eight-deep FIFO, then drain in order.
        for (int i = 0; i < 9; i++) push_ev(10'(10'h100 + i));
        check("full_count", 32'(fifo_count), 32'd8);
        check("full_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 10'h000, 1'b1, 1'b0);
        check("drain_last", 32'(last_pop), 32'h107);
        check("drain_count", 32'(fifo_count), 32'd0);

        // Flush in the same cycle as a push, with three queued and overflow still set.
        for (int i = 0; i < 3; i++) push_ev(10'(10'h180 + i));
        step(1'b1, 10'h3FF, 1'b0, 1'b1);
        check("flush_count", 32'(fifo_count), 32'd0);
        check("flush_valid", 32'(ev_valid), 32'd0);
        check("flush_overflow", 32'(overflow), 32'd0);
        idle(1);

        // Simultaneous push and pop while full.
        for (int i = 0; i < 8; i++) push_ev(10'(10'h200 + i));
        step(1'b1, 10'h2AA, 1'b1, 1'b0);
        check("pushpop_count", 32'(fifo_count), 32'd8);
        check("pushpop_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 10'h000, 1'b1, 1'b0);
        check("pushpop_last", 32'(last_pop), 32'h2AA);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 1)), 10'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 59) == 0));
        end
        step(1'b0, 10'h000, 1'b0, 1'b1);

        // Watchdog: a stalled 5-bit frame; queued events must survive the recovery.
        push_ev(10'h055);
        push_ev(10'h0AA);
        chk_rx_rst = 1'b0;
        for (int i = 0; i < 5; i++) ps2_fall();
        lows = 0; first_low = 0; last_low = 0;
        for (int i = 1; i <= 150; i++) begin
            idle(1);
            if (!rx_rst) begin
                lows++;
                if (first_low == 0) first_low = i;
                last_low = i;
            end
        end
        check("wd_low_cycles", 32'(lows), 32'd2);
        // Edge seen 3 clocks after ps2_clk drops, 8 of which elapsed inside the last fall.
        check("wd_first_low", 32'(first_low), 32'(TO + 3 - 8));
        check("wd_contiguous", 32'(last_low), 32'(first_low + 1));
        check("wd_timeout_cnt", 32'(timeout_cnt), 32'd1);
        check("wd_fifo_kept", 32'(fifo_count), 32'd2);

        // A full 11-edge frame after recovery must not trip again (bit count was cleared).
        lows = 0;
        for (int i = 0; i < 11; i++) ps2_fall();
        for (int i = 0; i < TO + 20; i++) begin
            idle(1);
            if (!rx_rst) lows++;
        end
        check("frame_no_recover", 32'(lows), 32'd0);
        check("frame_timeout_cnt", 32'(timeout_cnt), 32'd1);

        // Reset asserted during RECOVER.
        ps2_fall();
        ps2_fall();
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            idle(1);
            if (!rx_rst) seen = 1'b1;
        end
        check("recover_reached", 32'(seen), 32'd1);
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        check("rstrec_rx_rst", 32'(rx_rst), 32'd1);
        check("rstrec_timeout_cnt", 32'(timeout_cnt), 32'd0);
        check("rstrec_count", 32'(fifo_count), 32'd0);
        check("rstrec_valid", 32'(ev_valid), 32'd0);
        check("rstrec_data", 32'(ev_data), 32'd0);
        check("rstrec_overflow", 32'(overflow), 32'd0);
        exp_q.delete();
        exp_ovf = 1'b0;
        prev_rdy = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;
        chk_rx_rst = 1'b1;
        idle(TO + 20);
        push_ev(10'h0F0);
        check("post_rst_data", 32'(ev_data), 32'h0F0);
        check("post_rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
